mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage load/store controller sitting directly upstream of the word-wide data RAM.
//  Accepts one request at a time from EX/MEM: LB/LH/LW/LBU/LHU/SB/SH/SW.
//  Turns sub-word stores into a read-modify-write: the RAM has a single word write enable and no byte lanes.
//  Returns byte/halfword extracted, sign/zero-extended load data and a completion pulse to WB.
// PARAMETERS
//  ADDR_W    32     width of mem_addr / ram_addr
//  LD_RST    32'h0  reset value of rsp_rdata
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  mem_req    in   1       request valid from EX/MEM
//  mem_ready  out  1       controller can accept; request taken when mem_req & mem_ready
//  mem_we     in   1       1 = store, 0 = load
//  mem_funct3 in   3       RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  mem_addr   in   ADDR_W  byte address
//  mem_wdata  in   32      store data (rs2); low byte/half used for SB/SH
//  rsp_valid  out  1       one-cycle completion pulse (loads and stores)
//  rsp_rdata  out  32      extended load data, valid with rsp_valid on loads
//  rsp_err    out  1       access rejected, valid with rsp_valid
//  ram_en     out  1       RAM write enable
//  ram_addr   out  ADDR_W  RAM byte address; the RAM indexes words with [15:2]
//  ram_wdata  out  32      RAM write word
//  ram_rdata  in   32      RAM asynchronous read word at ram_addr
// BEHAVIOUR
//  Reset values
//  - state = IDLE; rsp_valid = 0; rsp_err = 0; rsp_rdata = LD_RST.
//  - Latched addr/funct3/wdata/merge registers = 0; ram_en = 0.
//  Outputs
//  - mem_ready = (state == IDLE).
//  - ram_en = (state == WRITE), purely decoded from state.
//  - ram_addr = latched addr with [1:0] forced to 0.
//  FSM: IDLE, LOAD, RMW_RD, WRITE. On accept, latch addr/funct3/we/wdata, then:
//  - Load -> LOAD.
//  - SW -> WRITE; ram_wdata = latched wdata.
//  - SB/SH -> RMW_RD.
//  - Illegal funct3 (011, 110, 111; or 100/101 with we=1) -> stay IDLE.
//    Next cycle: rsp_valid = 1, rsp_err = 1; no RAM write.
//  LOAD
//  - Select lane of ram_rdata by addr[1:0] (B) or addr[1] (H).
//  - Sign-extend for 000/001, zero-extend for 100/101.
//  - Register into rsp_rdata, pulse rsp_valid, -> IDLE.
//  - Latency: accept edge N, rsp_valid high in cycle N+2.
//  RMW_RD
//  - merge = ram_rdata with the addressed byte/half replaced by wdata[7:0]/[15:0].
//  - -> WRITE.
//  WRITE
//  - ram_en = 1, ram_wdata = merge (SB/SH) or wdata (SW).
//  - Pulse rsp_valid at the next edge, -> IDLE.
//  - Store latency: SW 2 cycles, SB/SH 3 cycles accept-to-rsp_valid.
//  rsp_rdata holds its last load value across stores and error responses.
//  Throughput: mem_ready rises in the same cycle as rsp_valid, allowing back-to-back requests.
//  mem_req while !mem_ready is ignored; the requester holds it.
//  Async reset in any state: ram_en drops immediately; no partial write; in-flight request discarded.
// CONFIGURATION
//  MISALIGN_TRAP_EN
//  - Defined: H with addr[0]=1 or W with addr[1:0]!=0 is treated as illegal.
//    Response is rsp_err = 1 one cycle after accept; RAM is untouched.
//  - Undefined: low address bits are ignored. W is aligned down; H uses addr[1] only.
//    rsp_err is raised only for illegal funct3.
// TESTING
//  1. Reset with RAM[0x10] = 32'h11223344; LW @0x10.
//     -> rsp_valid at cycle +2, rsp_rdata = 32'h11223344, rsp_err = 0.
//  2. LB @0x13 on 32'h80FF0000.
//     -> rsp_rdata = 32'hFFFFFF80. LBU @0x13 -> 32'h00000080.
//     LH @0x12 -> 32'hFFFF80FF.
//  3. SB @0x21 data 32'hAB over RAM 32'h11223344.
//     -> exactly one ram_en cycle, ram_wdata = 32'h1122AB44, rsp_valid at +3.
//  4. SW @0x30 immediately followed by LW @0x30 (mem_req held).
//     -> second request accepted on the rsp_valid cycle; the load returns the stored word.
//  5. LH @0x05 with MISALIGN_TRAP_EN.
//     -> rsp_err = 1, no ram_en, rsp_rdata unchanged.
//     Without the macro -> data from half at 0x04.
//  6. funct3 = 011; and rst_n pulsed low during WRITE.
//     -> rsp_err = 1. During the reset pulse ram_en falls asynchronously and outputs return to reset values.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller in front of a word-wide RAM with no byte lanes.
// Optional MISALIGN_TRAP_EN: reject misaligned H/W accesses instead of ignoring the low address bits.
module mem_access_ctrl #(
  parameter int          ADDR_W = 32,
  parameter logic [31:0] LD_RST = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  output logic              mem_ready,
  input  logic              mem_we,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on a rising edge where mem_req && mem_ready;
  // the requester holds mem_req and its payload stable until then.
  typedef enum logic [1:0] {IDLE, LOAD, RMW_RD, WRITE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;

  logic              req_legal;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;
  logic [31:0]       st_merge;

  always_comb begin
    req_legal = 1'b0;
    case (mem_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !mem_we;
      default:                req_legal = 1'b0;
    endcase
`ifdef MISALIGN_TRAP_EN
    if ((mem_funct3[1:0] == 2'b01 && mem_addr[0]) ||
        (mem_funct3 == 3'b010 && mem_addr[1:0] != 2'b00))
      req_legal = 1'b0;
`endif
  end

  // Lane selection ignores address bits below the access size.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = ram_rdata[7:0];
      2'b01:   ld_byte = ram_rdata[15:8];
      2'b10:   ld_byte = ram_rdata[23:16];
      default: ld_byte = ram_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = ram_rdata;
    endcase
  end

  always_comb begin
    st_merge = ram_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'b00:   st_merge[7:0]   = wdata_q[7:0];
        2'b01:   st_merge[15:8]  = wdata_q[7:0];
        2'b10:   st_merge[23:16] = wdata_q[7:0];
        default: st_merge[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      st_merge[31:16] = wdata_q[15:0];
    end else begin
      st_merge[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= LD_RST;
      addr_q    <= '0;
      funct3_q  <= 3'b000;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0;
      merge_q   <= 32'h0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            addr_q   <= mem_addr;
            funct3_q <= mem_funct3;
            we_q     <= mem_we;
            wdata_q  <= mem_wdata;
            // Rejected requests answer from IDLE so the RAM is never touched.
            if (!req_legal) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (!mem_we) begin
              state <= LOAD;
            end else if (mem_funct3 == 3'b010) begin
              state <= WRITE;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          rsp_rdata <= ld_data;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        RMW_RD: begin
          merge_q <= st_merge;
          state   <= WRITE;
        end
        WRITE: begin
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_ready = (state == IDLE);
  assign ram_en    = (state == WRITE);
  assign ram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign ram_wdata = (we_q && funct3_q == 3'b010) ? wdata_q : merge_q;
  assign dbg_state = state;

endmodule
